// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, {rem, quo} result.
// Operands are captured as magnitudes on accept; signs are reapplied on the final iteration.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [DATA_W-1:0]   dvd, dvd_nxt;
  logic [DATA_W-1:0]   dsr, dsr_nxt;
  logic [DATA_W-1:0]   rem, rem_nxt;
  logic [DATA_W-1:0]   quo, quo_nxt;
  logic                neg_q, neg_q_nxt;
  logic                neg_r, neg_r_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic                ready_nxt;

  // Trial subtraction: remainder stays below the divisor, so the shifted value fits W+1 bits.
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic                borrow;
  logic [DATA_W-1:0]   rem_new;
  logic [DATA_W-1:0]   quo_new;

  assign shifted           = {rem, dvd[DATA_W-1]};
  assign {borrow, diff}    = {1'b0, shifted} - {2'b00, dsr};
  assign rem_new           = borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_new           = {quo[DATA_W-2:0], ~borrow};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dvd_nxt    = dvd;
    dsr_nxt    = dsr;
    rem_nxt    = rem;
    quo_nxt    = quo;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    result_nxt = '0;
    ready_nxt  = 1'b0;
    case (state)
      FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = BYZERO;
          end else begin
            state_nxt = ON;
            cnt_nxt   = '0;
            dvd_nxt   = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
            dsr_nxt   = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
            rem_nxt   = '0;
            quo_nxt   = '0;
            neg_q_nxt = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r_nxt = signed_div_i && opdata1_i[DATA_W-1];
          end
        end
      end
      ON: begin
        if (annul_i || !start_i) begin
          state_nxt = FREE;
        end else begin
          rem_nxt = rem_new;
          quo_nxt = quo_new;
          dvd_nxt = dvd << 1;
          cnt_nxt = cnt + CW'(1);
          // Last bit: fold sign correction into the result register on the same edge.
          if (cnt == CW'(DATA_W - 1)) begin
            state_nxt  = END;
            ready_nxt  = 1'b1;
            result_nxt = {(neg_r ? -rem_new : rem_new), (neg_q ? -quo_new : quo_new)};
          end
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_nxt = FREE;
        end else begin
          state_nxt = END;
          ready_nxt = 1'b1;
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_nxt = FREE;
        end else begin
          ready_nxt  = 1'b1;
          result_nxt = result_o;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dvd      <= dvd_nxt;
      dsr      <= dsr_nxt;
      rem      <= rem_nxt;
      quo      <= quo_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider in the execute stage, directly downstream of the ID/EX pipeline register. Takes the latched operands (ex_reg1, ex_reg2) when the execute logic decodes a DIV/DIVU op, produces one quotient bit per cycle, and returns {remainder, quotient} for the HI/LO write path. While it runs, the execute stage holds its stall request so the ID/EX register freezes its contents.

## Interface
- DATA_W, 32, operand width; result is 2*DATA_W bits.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Asynchronous, active-low: rst==0 resets the block immediately, independent of clk.
- start_i  in  1  request a divide. Held high by the execute stage until the cycle after ready_o is seen.
- annul_i  in  1  cancel the current or requested divide (pipeline flush).
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- result_o  out  2*DATA_W  {remainder[2W-1:W], quotient[W-1:0]}. Registered.
- ready_o  out  1  result valid. Registered.

## Operation
- States: FREE, BYZERO, ON, END. Reset enters FREE with cnt=0, ready_o=0, result_o=0 and all internal registers zeroed.
- FREE: if start_i=1 and annul_i=0:
  - if opdata2_i==0, go to BYZERO;
  - else go to ON, cnt=0. Capture magnitudes: if signed_div_i and the operand MSB is set, store its two's-complement negation; otherwise store it unchanged. Also capture the sign flags.
  - Otherwise stay in FREE.
- ON: if annul_i=1 or start_i=0, go to FREE (abort, no result). Otherwise do one restoring iteration, MSB first:
  - shift the partial remainder left by 1 and bring in the next dividend bit;
  - trial-subtract the divisor magnitude at W+1 bits;
  - if the result is non-negative, keep it and shift in quotient bit 1; else keep the old remainder and shift in 0;
  - cnt++.
- When cnt reaches DATA_W, go to END:
  - quotient is negated if signed_div_i and the dividend and divisor signs differ;
  - remainder is negated if signed_div_i and the dividend is negative;
  - register result_o and set ready_o=1.
- BYZERO: go to END next cycle with result_o=0 and ready_o=1, unless annul_i=1, in which case go to FREE.
- END: hold result_o and ready_o while start_i=1. When start_i=0, go to FREE and clear ready_o and result_o to 0. annul_i in END also returns to FREE.
- ready_o=0 and result_o=0 in every state except END.
- Overflow: signed 0x80000000 / 0xFFFFFFFF wraps to quotient 0x80000000, remainder 0. No exception is raised.
- Operand inputs are ignored after the accepting edge; they may change freely during ON.

## Timing
- The accepting edge is edge 1 (FREE→ON).
- Iterations happen on edges 2..33. Edge 33 enters END, so ready_o is high after edge 33: 33-cycle latency.
- Divide by zero: FREE→BYZERO on edge 1, END after edge 2, so ready_o is high after edge 2.
- After ready_o is observed, start_i low forces FREE on the next edge. A new start_i is accepted on the edge after that; no back-to-back accept from END.
- annul_i and start_i=1 asserted together in FREE: not accepted.
- Reset asserted mid-operation: all outputs go to 0 combinationally from rst, with no clock edge needed. After rst deasserts, the block is in FREE.

## Test plan
- Unsigned 100 / 7, start held high: ready_o rises after edge 33 with result_o=0x00000002_0000000E, and stays there until start_i drops; on the next edge ready_o=0 and result_o=0.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002): result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). Signed 7 / -2: result_o=0x00000001_FFFFFFFD.
- Divisor 0, either signedness, dividend 0x1234: ready_o high after edge 2, result_o=0.
- Start, then annul_i pulsed at edge 10: FREE on that edge; ready_o never rises. A fresh 0xFFFFFFFF / 0x10 unsigned divide then yields 0x0000000F_0FFFFFFF after 33 edges.
- Signed 0x80000000 / 0xFFFFFFFF: result_o=0x00000000_80000000. Unsigned same operands: result_o=0x80000000_00000000.
- rst pulled low at edge 20 of a divide, between clock edges: ready_o and result_o are 0 immediately. After release, a new 9 / 3 divide returns 0x00000000_00000003.
